serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 a  input  WIDTH  minuend, captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend, captured on an accepted start.
REQ-007 bin  input  1  borrow-in, captured on an accepted start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse: results valid.
REQ-010 s  output  WIDTH  difference a-b-bin mod 2^WIDTH.
REQ-011 bout  output  1  unsigned borrow-out; 1 when a < b+bin.
REQ-012 underflow  output  1  two's-complement signed overflow of a-b-bin.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE/DONE with start=1: load a, b, bin into shift/borrow registers, clear bit counter, go to RUN.
REQ-015 IDLE with start=0 stays IDLE; DONE with start=0 goes to IDLE.
REQ-016 RUN, one bit per cycle, LSB first: d = a_i^b_i^br; br_next = (~a_i&b_i)|(~(a_i^b_i)&br); d shifted into result MSB.
REQ-017 RUN lasts exactly WIDTH cycles, then DONE; busy=1 exactly in RUN.
REQ-018 done=1 exactly in DONE; edge sampling start to done high = WIDTH+1 cycles.
REQ-019 s, bout, underflow update only on the RUN->DONE transition, then hold until the next completion.
REQ-020 underflow = borrow into MSB XOR borrow out of MSB.
REQ-021 start while busy=1 ignored; a, b, bin changes during RUN do not affect the result.
REQ-022 start in the DONE cycle accepted: done pulses and RUN begins next cycle; back-to-back operations cost WIDTH+1 cycles each.
REQ-023 Counter wraps by reload only; no state beyond bit WIDTH-1 is processed.

Reset
REQ-024 rst=1 forces IDLE immediately, independent of clk.
REQ-025 Reset values: busy=0, done=0, s=0, bout=0, underflow=0, internal registers 0.
REQ-026 Reset mid-RUN aborts the operation; no done pulse; the partial result is discarded.
REQ-027 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro SERIAL_SUB_SATURATE_EN defined: on completion with bout=1, s=0 (unsigned clamp); bout and underflow unchanged.
REQ-029 Macro undefined: s is always the wrapped difference; no saturation logic present.

Structure
REQ-030 Package serial_sub_pkg: FSM state enum, default width constant, counter width derived from WIDTH.
REQ-031 Sub-module sub_bit_cell: combinational 1-bit full subtractor (a_i, b_i, br -> d, br_next), one instance.

Verification (WIDTH=4)
REQ-032 a=7, b=1, bin=0 -> done after 5 cycles, s=6, bout=0, underflow=0.
REQ-033 a=1, b=15, bin=0 -> s=2, bout=1, underflow=0; with SERIAL_SUB_SATURATE_EN: s=0.
REQ-034 a=8, b=1, bin=0 -> s=7, bout=0, underflow=1.
REQ-035 a=5, b=13, bin=1 -> s=7, bout=1, underflow=0; start pulsed at RUN cycle 2 with a=0, b=0 -> ignored, result unchanged.
REQ-036 rst raised at RUN cycle 2 -> busy=0 and all outputs 0 immediately; no done; next start a=8, b=8 -> s=0, bout=0.
REQ-037 Back-to-back: start held high through DONE -> second done exactly 5 cycles after the first, with correct second result.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand/result width
//   cnt_width()    : bit-counter width needed to index WIDTH bits
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
//   start      : request, sampled only while busy=0
//   a, b, bin  : minuend, subtrahend and borrow-in, captured on accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, results valid
//   s          : difference a-b-bin mod 2^WIDTH
//   bout       : unsigned borrow-out
//   underflow  : two's-complement signed overflow
// master = requester side, slave = subtractor side.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             bout;
    logic             underflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, s, bout, underflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, s, bout, underflow
    );

endinterface

// File: rtl/serial_subtractor_bit_cell.sv
// sub_bit_cell: combinational 1-bit full subtractor.
//   a_i, b_i : operand bits
//   br       : borrow in
//   d        : difference bit
//   br_next  : borrow out
module sub_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = a_i ^ b_i ^ br;
    assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b-bin one bit per clock, LSB first,
// through a single sub_bit_cell. An accepted start loads the operands,
// RUN lasts WIDTH cycles, DONE holds for one cycle with done=1. A start
// seen in DONE begins the next operation immediately.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_subtractor_if.slave (start/a/b/bin in,
//          busy/done/s/bout/underflow out)
// Optional build macro:
//   SERIAL_SUB_SATURATE_EN : clamp s to 0 when the result borrows out
//                            (bout and underflow unaffected).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;      // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0] b_sr;      // subtrahend, shifted right each RUN cycle
    logic [WIDTH-2:0] r_sr;      // difference bits produced so far, MSB-aligned
    logic             br;        // running borrow
    logic [CNT_W-1:0] cnt;       // index of the bit being processed

    logic [WIDTH-1:0] s_q;
    logic             bout_q;
    logic             underflow_q;

    logic             d;
    logic             br_next;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] diff_full; // partial result with the current bit at the MSB
    logic [WIDTH-1:0] s_final;

    sub_bit_cell u_cell (
        .a_i     (a_sr[0]),
        .b_i     (b_sr[0]),
        .br      (br),
        .d       (d),
        .br_next (br_next)
    );

    // On the last RUN cycle this is the complete difference.
    assign diff_full = {d, r_sr};

`ifdef SERIAL_SUB_SATURATE_EN
    assign s_final = br_next ? '0 : diff_full;
`else
    assign s_final = diff_full;
`endif

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last_bit   = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt == LAST_IDX) begin
                    state_next = DONE;
                    last_bit   = 1'b1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every datapath register is reset, so an aborted operation leaves
    // no partial result behind and the outputs read 0 straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            r_sr        <= '0;
            br          <= 1'b0;
            cnt         <= '0;
            s_q         <= '0;
            bout_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (load) begin
                a_sr <= bus.a;
                b_sr <= bus.b;
                br   <= bus.bin;
                r_sr <= '0;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                br   <= br_next;
                r_sr <= diff_full[WIDTH-1:1];
                // Counter is only ever restarted by a load, never wrapped.
                if (!last_bit) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Results change only on RUN->DONE and hold until the next one.
            if (last_bit) begin
                s_q         <= s_final;
                bout_q      <= br_next;
                // Signed overflow: borrow into the MSB differs from borrow out.
                underflow_q <= br ^ br_next;
            end
        end
    end

    assign bus.s         = s_q;
    assign bus.bout      = bout_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W   = 4;
    localparam int LAT = W + 1;   // sampling edge to done-high, edges inclusive

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] s;
        logic         bout;
        logic         uf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] s, output logic bout, output logic uf);
        int diff;
        int sa;
        int sb;
        int sd;
        diff = int'(a) - int'(b) - int'(bin);
        s    = W'(diff);
        bout = (diff < 0);
        sa   = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb   = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        sd   = sa - sb - int'(bin);
        uf   = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
`ifdef SERIAL_SUB_SATURATE_EN
        if (bout) s = '0;
`endif
    endtask

    // Counts edges starting with the one that samples start; -1 on timeout.
    task automatic wait_done(input bit drop_start, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (drop_start && i == 0) bus.start = 1'b0;
            if (bus.done) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        wait_done(1'b1, lat);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] s, input logic bout,
                                input logic uf, input int lat);
        check({tag, " latency"},   lat,           LAT);
        check({tag, " s"},         bus.s,         s);
        check({tag, " bout"},      bus.bout,      bout);
        check({tag, " underflow"}, bus.underflow, uf);
    endtask

    initial begin
        vec_t         vecs[7];
        int           lat;
        int           t1;
        int           t2;
        int           done_seen;
        logic [W-1:0] es;
        logic         eb;
        logic         eu;

        // Wrapped-difference expectations worked out by hand.
        vecs[0] = '{a: 4'd7,  b: 4'd1,  bin: 1'b0, s: 4'd6,  bout: 1'b0, uf: 1'b0};
        vecs[1] = '{a: 4'd1,  b: 4'd15, bin: 1'b0, s: 4'd2,  bout: 1'b1, uf: 1'b0};
        vecs[2] = '{a: 4'd8,  b: 4'd1,  bin: 1'b0, s: 4'd7,  bout: 1'b0, uf: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, s: 4'd15, bout: 1'b1, uf: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd15, bin: 1'b0, s: 4'd0,  bout: 1'b0, uf: 1'b0};
        vecs[5] = '{a: 4'd7,  b: 4'd8,  bin: 1'b0, s: 4'd15, bout: 1'b1, uf: 1'b1};
        vecs[6] = '{a: 4'd9,  b: 4'd2,  bin: 1'b1, s: 4'd6,  bout: 1'b0, uf: 1'b1};
`ifdef SERIAL_SUB_SATURATE_EN
        foreach (vecs[i]) if (vecs[i].bout) vecs[i].s = '0;
`endif

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",      bus.busy,      0);
        check("reset done",      bus.done,      0);
        check("reset s",         bus.s,         0);
        check("reset bout",      bus.bout,      0);
        check("reset underflow", bus.underflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].bout, vecs[i].uf, lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse", i), bus.done, 0);
            check($sformatf("vec%0d hold s", i),     bus.s,    vecs[i].s);
        end

        // start while busy is ignored; operand changes during RUN ignored
        model(4'd5, 4'd13, 1'b1, es, eb, eu);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd13; bus.bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign busy", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd0; bus.b = 4'd0; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1'b0, lat);
        check("ign latency", (lat < 0) ? -1 : lat + 3, LAT);
        check("ign s",         bus.s,         es);
        check("ign bout",      bus.bout,      eb);
        check("ign underflow", bus.underflow, eu);
        @(posedge clk);
        #1;
        check("ign idle busy", bus.busy, 0);

        // Reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd1; bus.bin = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst busy",      bus.busy,      0);
        check("rst done",      bus.done,      0);
        check("rst s",         bus.s,         0);
        check("rst bout",      bus.bout,      0);
        check("rst underflow", bus.underflow, 0);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("rst no done", done_seen, 0);
        // First start presented with the reset release edge-aligned
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1; bus.a = 4'd8; bus.b = 4'd8; bus.bin = 1'b0;
        wait_done(1'b1, lat);
        check_result("post-rst", 4'd0, 1'b0, 1'b0, lat);

        // Back-to-back with start held through DONE
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0;
        @(posedge clk);
        #1;
        bus.a = 4'd2; bus.b = 4'd5; bus.bin = 1'b1;
        wait_done(1'b0, lat);
        t1 = (lat < 0) ? -1 : lat + 1;
        model(4'd9, 4'd3, 1'b0, es, eb, eu);
        check_result("b2b first", es, eb, eu, t1);
        wait_done(1'b1, t2);
        model(4'd2, 4'd5, 1'b1, es, eb, eu);
        check_result("b2b second", es, eb, eu, t2);

        // Random operands against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbin;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, es, eb, eu);
            run_op(ra, rb, rbin, lat);
            check_result($sformatf("rnd%0d a=%0d b=%0d bin=%0d", n, ra, rb, rbin), es, eb, eu, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
